// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: two-lane HUB75 scan engine with binary-coded-modulation bit-planes
// and global brightness, fed from a dual-buffered RGB565 pixel RAM.
module hub75_bcm_driver #(
   parameter int PANEL_WIDTH  = 64,
   parameter int ROW_BITS     = 5,
   parameter int BCM_BITS     = 4,
   parameter int CLK_HALF     = 2,
   parameter int LATCH_CYCLES = 2,
   parameter int BASE_TICKS   = 64,
   localparam int COL_BITS    = $clog2(PANEL_WIDTH),
   localparam int AW          = 2 + ROW_BITS + COL_BITS
) (
   input  logic                clk_48mhz,
   input  logic                reset,
   input  logic [7:0]          i_brightness,
   input  logic                i_buffer_sel,
   output logic [AW-1:0]       o_ram_addr,
   output logic                o_ram_rd_stb,
   input  logic [15:0]         i_ram_data,
   output logic                o_data_clock,
   output logic                o_data_latch,
   output logic                o_data_blank,
   output logic [1:0]          o_data_r,
   output logic [1:0]          o_data_g,
   output logic [1:0]          o_data_b,
   output logic [ROW_BITS-1:0] o_row_select,
   output logic                o_frame_stb
);
   localparam int PW  = BCM_BITS > 1 ? $clog2(BCM_BITS) : 1;
   localparam int SW  = $clog2((CLK_HALF > LATCH_CYCLES ? CLK_HALF : LATCH_CYCLES) + 1);
   localparam int CW  = $clog2(BASE_TICKS + 1) + BCM_BITS;
   localparam int PRW = CW + 8;

   typedef enum logic [2:0] {FETCH_TOP, FETCH_BOT, PRESENT, CLOCK, WAIT_DISP, LATCH} state_t;

   state_t              state_q, state_d;
   logic                active_q, buf_q, buf_d;
   logic [COL_BITS-1:0] col_q, col_d;
   logic [ROW_BITS-1:0] row_q, row_d, row_sel_q, row_sel_d;
   logic [PW-1:0]       plane_q, plane_d;
   logic [SW-1:0]       sub_q, sub_d;
   logic [15:0]         top_q, top_d;
   logic [5:0]          rgb_q, rgb_d;
   logic [CW-1:0]       cnt_q, cnt_d, thr_q, thr_d, period, on_w;
   logic                sub_end, frame_start, load, last_plane;

   // {r,g,b} of one pixel for plane p, taken from the MSB end of each channel
   function automatic logic [2:0] plane_bits(input logic [15:0] px, input logic [PW-1:0] p);
      return {px[4'(16 - BCM_BITS) + 4'(p)], px[4'(11 - BCM_BITS) + 4'(p)], px[4'(5 - BCM_BITS) + 4'(p)]};
   endfunction

   assign sub_end     = sub_q == (state_q == LATCH ? SW'(LATCH_CYCLES - 1) : SW'(CLK_HALF - 1));
   assign frame_start = active_q && state_q == FETCH_TOP && col_q == '0 && row_q == '0 && plane_q == '0;
   assign load        = state_q == LATCH && sub_end;
   assign last_plane  = plane_q == PW'(BCM_BITS - 1);
   assign period      = CW'(BASE_TICKS) << plane_q;
   assign on_w        = CW'((PRW'(i_brightness) * PRW'(period)) >> 8);

   always_comb begin
      buf_d     = frame_start ? i_buffer_sel : buf_q;
      top_d     = state_q == FETCH_BOT ? i_ram_data : top_q;
      rgb_d     = state_q == PRESENT && sub_q == '0 ?
                  {plane_bits(top_q, plane_q), plane_bits(i_ram_data, plane_q)} : rgb_q;
      cnt_d     = load ? period : cnt_q - CW'(cnt_q != '0);
      thr_d     = load ? period - on_w : thr_q;
      sub_d     = (state_q inside {PRESENT, CLOCK, LATCH}) && !sub_end ? sub_q + SW'(1) : '0;
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      plane_d   = plane_q;
      if (active_q)
         case (state_q)
            FETCH_TOP: state_d = FETCH_BOT;
            FETCH_BOT: state_d = PRESENT;
            PRESENT:   state_d = sub_end ? CLOCK : PRESENT;
            CLOCK:
               if (sub_end) begin
                  col_d   = col_q + COL_BITS'(1);
                  state_d = col_q != COL_BITS'(PANEL_WIDTH - 1) ? FETCH_TOP :
                            cnt_q == '0 ? LATCH : WAIT_DISP;
               end
            WAIT_DISP: state_d = cnt_q == '0 ? LATCH : WAIT_DISP;
            default:
               if (sub_end) begin
                  state_d = FETCH_TOP;
                  plane_d = last_plane ? '0 : plane_q + PW'(1);
                  row_d   = last_plane ? row_q + ROW_BITS'(1) : row_q;
               end
         endcase
      row_sel_d = state_q != LATCH && state_d == LATCH ? row_q : row_sel_q;
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q   <= FETCH_TOP;
         active_q  <= 1'b0;
         buf_q     <= 1'b0;
         col_q     <= '0;
         row_q     <= '0;
         row_sel_q <= '0;
         plane_q   <= '0;
         sub_q     <= '0;
         top_q     <= '0;
         rgb_q     <= '0;
         cnt_q     <= '0;
         thr_q     <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= 1'b1;
         buf_q     <= buf_d;
         col_q     <= col_d;
         row_q     <= row_d;
         row_sel_q <= row_sel_d;
         plane_q   <= plane_d;
         sub_q     <= sub_d;
         top_q     <= top_d;
         rgb_q     <= rgb_d;
         cnt_q     <= cnt_d;
         thr_q     <= thr_d;
      end
   end

   // the bottom pixel arrives during the first PRESENT cycle, so rgb_d drives the pins directly
   assign o_ram_rd_stb = active_q && (state_q == FETCH_TOP || state_q == FETCH_BOT);
   assign o_ram_addr   = {buf_d, state_q == FETCH_BOT, row_q, col_q};
   assign o_data_clock = state_q == CLOCK;
   assign o_data_latch = state_q == LATCH;
   assign o_data_blank = state_q == LATCH || cnt_q <= thr_q;
   assign o_data_r     = {rgb_d[2], rgb_d[5]};
   assign o_data_g     = {rgb_d[1], rgb_d[4]};
   assign o_data_b     = {rgb_d[0], rgb_d[3]};
   assign o_row_select = row_sel_q;
   assign o_frame_stb  = frame_start;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: directed bench for hub75_bcm_driver at default parameters,
// with a one-cycle-latency RAM returning red for the upper half and blue for the lower half.
module tb_hub75_bcm_driver;
   logic        clk_48mhz;
   logic        reset;
   logic [7:0]  brightness;
   logic        buffer_sel;
   logic [12:0] ram_addr;
   logic        ram_rd_stb;
   logic [15:0] ram_data;
   logic        data_clock, data_latch, data_blank, frame_stb;
   logic [1:0]  r, g, b;
   logic [4:0]  row_sel;
   int          checks = 0;
   int          fails = 0;

   hub75_bcm_driver dut (
      .clk_48mhz(clk_48mhz), .reset(reset), .i_brightness(brightness), .i_buffer_sel(buffer_sel),
      .o_ram_addr(ram_addr), .o_ram_rd_stb(ram_rd_stb), .i_ram_data(ram_data),
      .o_data_clock(data_clock), .o_data_latch(data_latch), .o_data_blank(data_blank),
      .o_data_r(r), .o_data_g(g), .o_data_b(b), .o_row_select(row_sel), .o_frame_stb(frame_stb)
   );

   initial clk_48mhz = 1'b0;
   always #5 clk_48mhz = ~clk_48mhz;

   always_ff @(posedge clk_48mhz)
      if (ram_rd_stb) ram_data <= ram_addr[11] ? 16'h001F : 16'hF800;

   task automatic tick();
      @(posedge clk_48mhz);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // run until the next latch pulse, gathering shift and display statistics
   task automatic scan(output int lows, output int edges, output int bad_sp, output int bad_rgb, output bit to);
      int   last = -1;
      logic pc = 1'b0;
      lows = 0; edges = 0; bad_sp = 0; bad_rgb = 0; to = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (data_latch) begin
            to = 1'b0;
            break;
         end
         if (!data_blank) lows++;
         if (data_clock && !pc) begin
            edges++;
            if (last >= 0 && i - last != 6) bad_sp++;
            last = i;
            if ({r, g, b} !== 6'b01_00_10) bad_rgb++;
         end
         pc = data_clock;
         tick();
      end
   endtask

   task automatic latch_len(output int n, output int bad);
      n = 0; bad = 0;
      for (int i = 0; i < 100 && data_latch; i++) begin
         n++;
         if (!data_blank) bad++;
         tick();
      end
   endtask

   initial begin
      int   lows, edges, bsp, brgb, n, bad, badbuf;
      bit   to, found;
      logic pl;
      int   exp255[4];
      exp255 = '{63, 127, 255, 510};
      reset = 1'b1; brightness = 8'd128; buffer_sel = 1'b0;
      repeat (5) tick();
      check("rst_blank", data_blank, 1);
      check("rst_latch", data_latch, 0);
      check("rst_clock", data_clock, 0);
      check("rst_rd_stb", ram_rd_stb, 0);
      check("rst_frame_stb", frame_stb, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_rgb", {r, g, b}, 0);
      check("rst_row", row_sel, 0);
      reset = 1'b0;
      tick();
      check("first_rd_stb", ram_rd_stb, 1);
      check("first_addr", ram_addr, 0);
      check("first_frame_stb", frame_stb, 1);
      scan(lows, edges, bsp, brgb, to);
      check("p0_timeout", to, 0);
      check("p0_edges", edges, 64);
      check("p0_spacing", bsp, 0);
      check("p0_rgb", brgb, 0);
      check("p0_dark_before_latch", lows, 0);
      check("latch_row0", row_sel, 0);
      for (int p = 0; p < 4; p++) begin
         latch_len(n, bad);
         check($sformatf("latch_len_%0d", p), n, 2);
         check($sformatf("latch_blank_%0d", p), bad, 0);
         scan(lows, edges, bsp, brgb, to);
         check($sformatf("scan_timeout_%0d", p), to, 0);
         check($sformatf("edges_%0d", p), edges, 64);
         check($sformatf("spacing_%0d", p), bsp, 0);
         check($sformatf("rgb_%0d", p), brgb, 0);
         check($sformatf("b128_on_plane%0d", p), lows, 32 << p);
      end
      check("latch_row1", row_sel, 1);

      brightness = 8'd0; reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst2_frame_stb", frame_stb, 1);
      lows = 0; n = 0; bad = 0; badbuf = 0; found = 1'b0; pl = 1'b0;
      for (int i = 0; i < 60000; i++) begin
         tick();
         if (frame_stb) begin
            found = 1'b1;
            break;
         end
         if (!data_blank) lows++;
         if (data_latch && !pl) begin
            if (row_sel !== 5'(n >> 2)) bad++;
            n++;
         end
         pl = data_latch;
         if (ram_rd_stb && ram_addr[12]) badbuf++;
         if (i == 20000) buffer_sel = 1'b1;
      end
      check("frame_found", found, 1);
      check("b0_never_unblank", lows, 0);
      check("frame_latches", n, 128);
      check("row_sequence", bad, 0);
      check("buf_held_midframe", badbuf, 0);
      check("buf_new_at_frame", ram_addr[12], 1);
      scan(lows, edges, bsp, brgb, to);
      check("wrap_timeout", to, 0);
      check("row_wrap", row_sel, 0);
      check("b0_dark_after_wrap", lows, 0);

      brightness = 8'd255;
      for (int k = 1; k < 8; k++) begin
         latch_len(n, bad);
         scan(lows, edges, bsp, brgb, to);
         check($sformatf("b255_timeout_%0d", k), to, 0);
         check($sformatf("b255_on_%0d", k), lows, exp255[(k - 1) % 4]);
      end
      check("row1_plane3_row", row_sel, 1);
      latch_len(n, bad);
      edges = 0; pl = 1'b0; to = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (data_clock && !pl) begin
            edges++;
            if (edges == 31) begin
               to = 1'b0;
               break;
            end
         end
         pl = data_clock;
         tick();
      end
      check("col30_found", to, 0);
      check("col30_clock", data_clock, 1);
      check("col30_unblanked", data_blank, 0);
      reset = 1'b1;
      tick();
      check("midrst_clock", data_clock, 0);
      check("midrst_blank", data_blank, 1);
      check("midrst_row", row_sel, 0);
      check("midrst_latch", data_latch, 0);
      check("midrst_rd_stb", ram_rd_stb, 0);
      buffer_sel = 1'b0; reset = 1'b0;
      tick();
      check("restart_rd_stb", ram_rd_stb, 1);
      check("restart_addr", ram_addr, 0);
      check("restart_frame_stb", frame_stb, 1);
      scan(lows, edges, bsp, brgb, to);
      check("restart_timeout", to, 0);
      check("restart_edges", edges, 64);
      check("restart_dark", lows, 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
